// File: rtl/pkg_barreira.sv
// Shared definitions for the light-barrier path: ranging FSM states and
// the distance width also consumed by the barrier comparator.
package pkg_barreira;

  localparam int DIST_W = 8;
  localparam logic [DIST_W-1:0] DIST_MAX = 8'd255;

  typedef enum logic [2:0] {
    OCIOSO,
    DISPARO,
    ESPERA_ECO,
    MEDINDO,
    ESPERA_PERIODO
  } estado_t;

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for asynchronous sensor pins, clears to 0 on reset.
module sincronizador_2ff #(
  parameter int LARGURA = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LARGURA-1:0] d,
  output logic [LARGURA-1:0] q
);

  logic [LARGURA-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/controle_sensor_distancia.sv
// Ultrasonic ranging sequencer: periodic trigger, echo width timing and
// conversion to whole centimetres with timeout/overrange reporting.
module controle_sensor_distancia
  import pkg_barreira::*;
#(
  parameter int TRIG_CICLOS    = 1000,
  parameter int CICLOS_POR_CM  = 5800,
  parameter int TIMEOUT_CICLOS = 3000000,
  parameter int PERIODO_CICLOS = 6000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              habilita,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] distancia_cm,
  output logic              medida_valida,
  output logic              timeout_err,
  output logic              ocupado
);

  localparam int TMR_MAX = (TIMEOUT_CICLOS > TRIG_CICLOS) ? TIMEOUT_CICLOS : TRIG_CICLOS;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam int PER_W   = $clog2(PERIODO_CICLOS);
  localparam int PRE_W   = $clog2(CICLOS_POR_CM);

  estado_t           estado, prox;
  logic [TMR_W-1:0]  tmr, tmr_prox;
  logic [PER_W-1:0]  per_cnt;
  logic [PRE_W-1:0]  pre, pre_prox;
  logic [DIST_W:0]   cm, cm_prox;
  logic [DIST_W-1:0] dist_prox;
  logic              valida_prox, erro_prox;
  logic              echo_s, echo_d, sobe, desce;

  sincronizador_2ff #(.LARGURA(1)) u_sinc_echo (
    .clk (clk),
    .rst (rst),
    .d   (echo),
    .q   (echo_s)
  );

  assign sobe  = echo_s & ~echo_d;
  assign desce = ~echo_s & echo_d;

  always_comb begin
    prox        = estado;
    tmr_prox    = tmr;
    pre_prox    = pre;
    cm_prox     = cm;
    dist_prox   = distancia_cm;
    valida_prox = 1'b0;
    erro_prox   = 1'b0;
    case (estado)
      OCIOSO: begin
        if (habilita) begin
          prox     = DISPARO;
          tmr_prox = TMR_W'(TRIG_CICLOS - 1);
        end
      end
      DISPARO: begin
        if (!habilita) begin
          prox = OCIOSO;
        end else if (tmr == '0) begin
          prox     = ESPERA_ECO;
          tmr_prox = TMR_W'(TIMEOUT_CICLOS - 1);
        end else begin
          tmr_prox = tmr - 1'b1;
        end
      end
      ESPERA_ECO: begin
        if (!habilita) begin
          prox = OCIOSO;
        end else if (sobe) begin
          // the edge cycle is itself the first echo-high cycle
          prox     = MEDINDO;
          pre_prox = PRE_W'(1);
          cm_prox  = '0;
        end else if (tmr == '0) begin
          prox        = ESPERA_PERIODO;
          dist_prox   = DIST_MAX;
          valida_prox = 1'b1;
          erro_prox   = 1'b1;
        end else begin
          tmr_prox = tmr - 1'b1;
        end
      end
      MEDINDO: begin
        if (!habilita) begin
          prox = OCIOSO;
        end else if (desce) begin
          prox        = ESPERA_PERIODO;
          dist_prox   = cm[DIST_W-1:0];
          valida_prox = 1'b1;
        end else if (echo_s) begin
          if (pre == PRE_W'(CICLOS_POR_CM - 1)) begin
            pre_prox = '0;
            cm_prox  = cm + 1'b1;
            if (cm_prox[DIST_W]) begin
              prox        = ESPERA_PERIODO;
              dist_prox   = DIST_MAX;
              valida_prox = 1'b1;
              erro_prox   = 1'b1;
            end
          end else begin
            pre_prox = pre + 1'b1;
          end
        end
      end
      ESPERA_PERIODO: begin
        // per_cnt saturates, so an overrun retriggers as soon as echo is low
        if (per_cnt == PER_W'(PERIODO_CICLOS - 1) && !echo_s) begin
          if (habilita) begin
            prox     = DISPARO;
            tmr_prox = TMR_W'(TRIG_CICLOS - 1);
          end else begin
            prox = OCIOSO;
          end
        end
      end
      default: prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado        <= OCIOSO;
      tmr           <= '0;
      pre           <= '0;
      cm            <= '0;
      per_cnt       <= '0;
      echo_d        <= 1'b0;
      distancia_cm  <= DIST_MAX;
      medida_valida <= 1'b0;
      timeout_err   <= 1'b0;
      trig          <= 1'b0;
      ocupado       <= 1'b0;
    end else begin
      estado        <= prox;
      tmr           <= tmr_prox;
      pre           <= pre_prox;
      cm            <= cm_prox;
      echo_d        <= echo_s;
      distancia_cm  <= dist_prox;
      medida_valida <= valida_prox;
      timeout_err   <= erro_prox;
      trig          <= (prox == DISPARO);
      ocupado       <= (prox inside {DISPARO, ESPERA_ECO, MEDINDO});
      if (prox == DISPARO && estado != DISPARO)
        per_cnt <= '0;
      else if (per_cnt != PER_W'(PERIODO_CICLOS - 1))
        per_cnt <= per_cnt + 1'b1;
    end
  end

endmodule
